// File: rtl/bus_probe_pkg.sv
// Shared constants and glyph table for the bus probe display.
// Seven-segment glyphs are active-low, with segments g..a on bits 6..0.
package bus_probe_pkg;

  localparam logic [1:0] CH_ADDR  = 2'd0;
  localparam logic [1:0] CH_DATA  = 2'd1;
  localparam logic [1:0] CH_SPLIT = 2'd2;
  localparam logic [1:0] CH_COUNT = 2'd3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bus_probe_display_key_debouncer.sv
// Push-button debouncer: 2-FF synchroniser, stability counter and a registered
// one-cycle press pulse raised together with the debounced 1->0 transition.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          press_r;
  logic [CW-1:0] cnt_r;

  // Synchronise the raw key, then accept a new level only after it has been stable long enough.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      level_r <= 1'b1;
      cnt_r   <= '0;
      press_r <= 1'b0;
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
      press_r <= 1'b0;
      if (sync2_r != level_r) begin
        if (cnt_r == LIMIT) begin
          level_r <= sync2_r;
          cnt_r   <= '0;
          press_r <= ~sync2_r;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

  assign press = press_r;

endmodule

// File: rtl/bus_probe_display.sv
// Passive CPU-memory bus probe: captures the last completed transaction and a
// transaction count, and shows a selected channel on seven-segment digits.
module bus_probe_display
  import bus_probe_pkg::*;
#(
  parameter int NUM_DIGITS      = 8,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic                    mem_ack,
  input  logic [ADDR_W-1:0]       mem_addr,
  input  logic [DATA_W-1:0]       mem_read_data,
  input  logic [DATA_W-1:0]       mem_write_data,
  input  logic                    key_freeze_n,
  input  logic [1:0]              sel,
  output logic [NUM_DIGITS*7-1:0] hex_out,
  output logic                    frozen,
  output logic                    last_write,
  output logic                    proto_err,
  output logic [CNT_W-1:0]        txn_count
);

  localparam int VW = NUM_DIGITS * 4;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $fatal(1, "bus_probe_display: NUM_DIGITS must be 1..8");
  end

  logic [ADDR_W-1:0]       addr_r;
  logic [DATA_W-1:0]       data_r;
  logic [CNT_W-1:0]        cnt_r;
  logic                    ack_d_r;
  logic                    frozen_r;
  logic                    last_write_r;
  logic                    err_r;
  logic [NUM_DIGITS*7-1:0] hex_r;
  logic                    press_s;
  logic                    done_s;
  logic [VW-1:0]           val_s;
  logic [6:0]              src_w_s;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_freeze_key (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_freeze_n),
    .press (press_s)
  );

  assign done_s = mem_ack & ~ack_d_r;

  // Capture on the ack rising edge; frozen gates capture with its pre-toggle value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_r       <= '0;
      data_r       <= '0;
      cnt_r        <= '0;
      ack_d_r      <= 1'b0;
      frozen_r     <= 1'b0;
      last_write_r <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      ack_d_r <= mem_ack;
      if (press_s) frozen_r <= ~frozen_r;
      if (done_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
        if (mem_read == mem_write) err_r <= 1'b1;
        if (!frozen_r) begin
          addr_r       <= mem_addr;
          data_r       <= mem_write ? mem_write_data : mem_read_data;
          last_write_r <= mem_write;
        end
      end
    end
  end

  // Channel mux; src_w_s is the source width used to blank digits past it.
  always_comb begin
    val_s   = '0;
    src_w_s = 7'd32;
    case (sel)
      CH_ADDR: begin
        val_s   = VW'(addr_r);
        src_w_s = 7'(ADDR_W);
      end
      CH_DATA: begin
        val_s   = VW'(data_r);
        src_w_s = 7'(DATA_W);
      end
      CH_SPLIT: begin
        val_s   = VW'({addr_r[15:0], data_r[15:0]});
        src_w_s = 7'd32;
      end
      CH_COUNT: begin
        val_s   = VW'(cnt_r);
        src_w_s = 7'(CNT_W);
      end
      default: begin
        val_s   = '0;
        src_w_s = 7'd0;
      end
    endcase
  end

  // Registered segment drive, one glyph per nibble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hex_r <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        hex_r[7*i +: 7] <= ((4 * i) >= int'(src_w_s)) ? SEG_BLANK : hex_to_seg(val_s[4*i +: 4]);
      end
    end
  end

  assign hex_out    = hex_r;
  assign frozen     = frozen_r;
  assign last_write = last_write_r;
  assign proto_err  = err_r;
  assign txn_count  = cnt_r;

endmodule

// File: tb/tb_bus_probe_display.sv
// Self-checking bench for bus_probe_display: a transaction-level model checked
// every cycle, plus hand-computed digit patterns for the directed scenarios.
module tb_bus_probe_display;

  localparam int DEB = 4;
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        rst_n, mem_read, mem_write, mem_ack, key_freeze_n;
  logic [31:0] mem_addr, mem_read_data, mem_write_data;
  logic [1:0]  sel;
  logic [55:0] hex_out;
  logic        frozen, last_write, proto_err;
  logic [15:0] txn_count;

  int n_checks = 0;
  int n_fail   = 0;

  bus_probe_display #(
    .NUM_DIGITS(8), .ADDR_W(32), .DATA_W(32), .CNT_W(16), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_read_data(mem_read_data), .mem_write_data(mem_write_data),
    .key_freeze_n(key_freeze_n), .sel(sel), .hex_out(hex_out), .frozen(frozen),
    .last_write(last_write), .proto_err(proto_err), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint      m_addr, m_data;
  int          m_cnt, m_run;
  bit          m_frozen, m_lw, m_err, m_prev, m_sync1, m_sync2, m_level, m_fall_d;
  bit          m_valid = 1'b0;
  logic [55:0] m_hex;

  function automatic logic [55:0] disp(input logic [1:0] s);
    longint      v;
    int          w;
    logic [55:0] r;
    case (s)
      2'd0:    begin v = m_addr; w = 32; end
      2'd1:    begin v = m_data; w = 32; end
      2'd2:    begin v = (m_addr % 65536) * 65536 + (m_data % 65536); w = 32; end
      default: begin v = m_cnt; w = 16; end
    endcase
    for (int i = 0; i < 8; i++)
      r[7*i +: 7] = (4 * i >= w) ? 7'h7F : GLYPH[(v >> (4 * i)) % 16];
    return r;
  endfunction

  always @(posedge clk) begin
    bit done, fall, toggle;
    if (!rst_n) begin
      m_addr = 0; m_data = 0; m_cnt = 0; m_run = 0;
      m_frozen = 0; m_lw = 0; m_err = 0; m_prev = 0;
      m_sync1 = 1; m_sync2 = 1; m_level = 1; m_fall_d = 0;
      m_hex = {8{7'h7F}};
      m_valid = 1'b1;
    end else begin
      m_hex = disp(sel);
      // key level accepted after DEB consecutive differing synchronised samples
      fall = 0;
      if (m_sync2 != m_level) begin
        m_run++;
        if (m_run == DEB) begin
          m_level = m_sync2;
          m_run = 0;
          fall = (m_level == 0);
        end
      end else begin
        m_run = 0;
      end
      m_sync2 = m_sync1;
      m_sync1 = key_freeze_n;
      toggle = m_fall_d;
      m_fall_d = fall;
      done = mem_ack && !m_prev;
      m_prev = mem_ack;
      if (done) begin
        m_cnt = (m_cnt + 1) % 65536;
        if (mem_read == mem_write) m_err = 1;
        if (!m_frozen) begin
          m_addr = mem_addr;
          m_data = mem_write ? mem_write_data : mem_read_data;
          m_lw = mem_write;
        end
      end
      if (toggle) m_frozen = !m_frozen;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_hex_out", hex_out, m_hex);
      check("cyc_frozen", frozen, m_frozen);
      check("cyc_last_write", last_write, m_lw);
      check("cyc_proto_err", proto_err, m_err);
      check("cyc_txn_count", txn_count, m_cnt);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic txn(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] rdat, input logic [31:0] wdat);
    mem_read = rd; mem_write = wr; mem_addr = a;
    mem_read_data = rdat; mem_write_data = wdat; mem_ack = 1'b1;
    cyc(1);
    mem_ack = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    cyc(2);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_ack = 1'b0;
    mem_addr = '0; mem_read_data = '0; mem_write_data = '0;
    key_freeze_n = 1'b1; sel = 2'd0;
    cyc(2);
    check("reset_blank", hex_out, {8{7'h7F}});
    rst_n = 1'b1;
    cyc(1);
    check("post_reset_zero", hex_out, {8{7'h40}});
    check("post_reset_count", txn_count, 16'd0);

    // read with ack held 3 cycles: one completion
    sel = 2'd1; mem_read = 1'b1; mem_addr = 32'h0000_1A2C; mem_read_data = 32'hDEAD_BEEF;
    mem_ack = 1'b1;
    cyc(3);
    check("read_count", txn_count, 16'd1);
    check("read_lw", last_write, 1'b0);
    check("read_hex", hex_out, {7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E});
    mem_ack = 1'b0; mem_read = 1'b0;
    cyc(1);

    // write, split view
    sel = 2'd2;
    txn(1'b0, 1'b1, 32'h0000_0040, 32'h0, 32'h1234_5678);
    check("split_hex", hex_out, {7'h40, 7'h40, 7'h19, 7'h40, 7'h12, 7'h02, 7'h78, 7'h00});
    check("write_lw", last_write, 1'b1);
    sel = 2'd3;
    cyc(1);
    check("count_hex", hex_out, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h24});

    // press -> frozen
    key_freeze_n = 1'b0; cyc(6); key_freeze_n = 1'b1; cyc(8);
    check("freeze_on", frozen, 1'b1);
    sel = 2'd0;
    txn(1'b0, 1'b1, 32'h0000_0099, 32'h0, 32'h5555_AAAA);
    check("frozen_addr_hex", hex_out, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h19, 7'h40});
    check("frozen_count", txn_count, 16'd3);

    // short glitch ignored, second press unfreezes
    key_freeze_n = 1'b0; cyc(2); key_freeze_n = 1'b1; cyc(8);
    check("glitch_ignored", frozen, 1'b1);
    key_freeze_n = 1'b0; cyc(6); key_freeze_n = 1'b1; cyc(8);
    check("freeze_off", frozen, 1'b0);

    // press and ack edge in the same cycle: capture uses pre-toggle frozen
    key_freeze_n = 1'b0; cyc(6);
    mem_write = 1'b1; mem_addr = 32'h0000_0077; mem_write_data = 32'hCAFE_F00D; mem_ack = 1'b1;
    cyc(1);
    mem_ack = 1'b0; mem_write = 1'b0; key_freeze_n = 1'b1;
    cyc(8);
    check("simul_frozen", frozen, 1'b1);
    check("simul_capture", hex_out, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h78, 7'h78});

    // protocol error: sticky until reset
    txn(1'b0, 1'b0, 32'h0000_0123, 32'h0, 32'h0);
    check("perr_set", proto_err, 1'b1);
    txn(1'b1, 1'b0, 32'h0000_0124, 32'h1, 32'h0);
    check("perr_sticky", proto_err, 1'b1);
    check("perr_count", txn_count, 16'd6);
    rst_n = 1'b0; cyc(2);
    check("rst_perr", proto_err, 1'b0);
    check("rst_frozen", frozen, 1'b0);
    check("rst_count", txn_count, 16'd0);
    rst_n = 1'b1; cyc(1);

    // both strobes high: error, captured as a write
    sel = 2'd1;
    txn(1'b1, 1'b1, 32'h0000_0005, 32'h0000_00EE, 32'h0000_00AB);
    check("both_lw", last_write, 1'b1);
    check("both_perr", proto_err, 1'b1);
    check("both_hex", hex_out, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h03});

    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
